imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that sits directly upstream of the pipelined core's instruction memory. It accepts a length-prefixed byte stream over a valid/ready interface and packs the bytes into instruction words. It writes each word into the instruction ROM/RAM write port, starting at address 0, and holds the core in reset until the image is fully written. It then releases the core and reports done or error.

## Interface
Parameters:
- INST_W, 26: instruction width in bits (matches the core's instruction format).
- ADDR_W, 10: instruction memory word-address width.
- BYTES_PER_WORD, 4: bytes per instruction word, equal to ceil(INST_W/8).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  byte-stream ready.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address being written.
- imem_wdata  out  INST_W  instruction word being written.
- core_rst  out  1  active-high reset to the core; released only in RUN.
- done  out  1  image loaded and core running.
- error  out  1  load aborted.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

## Operation
- States:
  - IDLE -> LEN_LO -> LEN_HI -> DATA -> (CHECK) -> RUN.
  - Any error goes to ERR.
- A byte transfers on a rising clk edge with rx_valid && rx_ready.
- IDLE: rx_ready=0. start goes to LEN_LO and clears words_loaded, the checksum and the byte index.
- LEN_LO / LEN_HI: capture the 16-bit word count N, little-endian.
- After LEN_HI:
  - N > 2^ADDR_W: go to ERR.
  - N = 0: go to CHECK (macro on) or RUN (macro off).
  - Otherwise go to DATA.
- DATA packing:
  - Bytes are packed little-endian; byte k fills bits [8k+7:8k] of a 32-bit assembly register.
  - After byte BYTES_PER_WORD-1, bits [31:INST_W] must be zero, otherwise go to ERR with no write.
  - A valid word gives, on the next cycle: imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=bits[INST_W-1:0].
  - words_loaded increments in that same cycle.
  - rx_ready=0 during the write cycle.
- When words_loaded reaches N after a write: go to CHECK (macro on) or RUN.
- RUN: core_rst=0, done=1, rx_ready=0.
- ERR: error=1, core_rst=1, rx_ready=0.
- start is honoured only in IDLE, RUN and ERR. It returns to LEN_LO and asserts core_rst the next cycle. start in the other states is ignored.
- rx_valid while rx_ready=0 is not consumed. Data is never dropped silently.
- Asynchronous reset mid-load goes to IDLE. A partial image is left in memory; no further writes occur.

## Timing
- Reset values:
  - state=IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst=1, done=0, error=0, words_loaded=0.
- All outputs are registered.
- start accepted at edge t: rx_ready=1 from cycle t+1.
- Write latency: imem_we is high exactly one cycle, the cycle after the last byte of a word is accepted.
- Minimum 5 cycles per word at full rx_valid (4 bytes + 1 write cycle).
- RUN entry: core_rst falls and done rises on the same edge. This is the edge after the final write, or after the checksum byte is accepted.
- Wrap: N = 2^ADDR_W writes addresses 0..2^ADDR_W-1, and words_loaded ends at 2^ADDR_W (needs ADDR_W+1 bits).

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum, mod 256, is kept over all DATA bytes only (length bytes excluded).
  - CHECK: rx_ready=1 and one byte is expected.
  - A byte equal to the sum goes to RUN; any other value goes to ERR.
- IMEM_LOADER_CHECKSUM_EN undefined: there is no CHECK state and no checksum logic. The image ends after word N.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERR);
  - the default INST_W, ADDR_W and BYTES_PER_WORD constants;
  - the LEN_BYTES=2 constant.
- One sub-module, byte_packer, holds:
  - the byte index counter and the 32-bit assembly register;
  - word_valid and upper_bits_nonzero outputs;
  - a clear input.
- The FSM, address counter and checksum stay in imem_loader.

## Test plan
- Single word: start, then bytes 01 00, then 78 56 34 02 -> one imem_we with addr 0, wdata 26'h2345678; then core_rst=0, done=1 (macro on: also send checksum 0x04).
- Three words, with rx_valid toggling every other cycle -> writes at addr 0,1,2 in order with correct data, and words_loaded=3.
- Format error: N=1, bytes 00 00 00 FC -> no imem_we, error=1, core_rst stays 1.
- Length overflow: N=2^ADDR_W+1 (0x0401 with ADDR_W=10) -> ERR immediately after LEN_HI, no writes.
- Reset asserted after 2 of 4 words -> all outputs at reset values on the next edge; a new start then loads correctly from addr 0.
- Macro on, wrong checksum -> all writes performed, then error=1, done=0; start from ERR reloads successfully.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Optional checksum trailer is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int DEF_INST_W         = 26;
  localparam int DEF_ADDR_W         = 10;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int LEN_BYTES          = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;

  modport slave  (input  rx_valid, rx_data, output rx_ready, imem_we, imem_addr, imem_wdata);
  modport master (output rx_valid, rx_data, input  rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word/flags reflect the byte being accepted
// so the loader can decide on the final byte's edge without an extra cycle.
module byte_packer #(
  parameter int INST_W         = 26,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic              upper_bits_nonzero,
  output logic [INST_W-1:0] word
);
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      asm_q, asm_d, merged;

  always_comb begin
    merged                         = asm_q;
    merged[{idx_q, 3'b000} +: 8]   = byte_in;
    word_valid                     = byte_en && (idx_q == LAST_IDX);
    word                           = merged[INST_W-1:0];
    upper_bits_nonzero             = |(merged >> INST_W);
    idx_d                          = idx_q;
    asm_d                          = asm_q;
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (byte_en) begin
      // restart from zero so stale bytes never leak into the next word
      idx_d = word_valid ? '0 : idx_q + 1'b1;
      asm_d = word_valid ? '0 : merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Length-prefixed program loader: packs bytes into words, writes imem, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte over the data.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INST_W         = DEF_INST_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);
  localparam int LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_e            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [LEN_W-1:0]  len_q, len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              rx_acc, pk_clear, pk_en, pk_word_valid, pk_upper_nz;
  logic [INST_W-1:0] pk_word;
  logic [LEN_W:0]    len_full;
  logic              img_done, go_err;

  assign rx_acc = bus.rx_valid && rx_ready_q;
  assign pk_en  = rx_acc && (state_q == ST_DATA);

  byte_packer #(.INST_W(INST_W), .BYTES_PER_WORD(BYTES_PER_WORD)) u_packer (
    .clk                (clk),
    .rst                (rst),
    .clear              (pk_clear),
    .byte_en            (pk_en),
    .byte_in            (bus.rx_data),
    .word_valid         (pk_word_valid),
    .upper_bits_nonzero (pk_upper_nz),
    .word               (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    rx_ready_d = rx_ready_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    error_d    = error_q;
    wl_d       = wl_q;
    len_d      = len_q;
    pk_clear   = 1'b0;
    img_done   = 1'b0;
    go_err     = 1'b0;
    len_full   = {1'b0, bus.rx_data, len_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      ST_LEN_LO: if (rx_acc) begin
        len_d[7:0] = bus.rx_data;
        state_d    = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_acc) begin
        len_d = len_full[LEN_W-1:0];
        if (len_full > MAX_WORDS)  go_err   = 1'b1;
        else if (len_full == '0)   img_done = 1'b1;
        else                       state_d  = ST_DATA;
      end
      ST_DATA: begin
        // write cycle: rx is stalled, decide whether more words follow
        if (we_q) begin
          if (LEN_W'(wl_q) == len_q) img_done   = 1'b1;
          else                       rx_ready_d = 1'b1;
        end else if (rx_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.rx_data;
`endif
          if (pk_word_valid) begin
            rx_ready_d = 1'b0;
            if (pk_upper_nz) go_err = 1'b1;
            else begin
              we_d    = 1'b1;
              addr_d  = wl_q[ADDR_W-1:0];
              wdata_d = pk_word;
              wl_d    = wl_q + 1'b1;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (rx_acc) begin
        if (bus.rx_data == sum_q) begin
          state_d    = ST_RUN;
          rx_ready_d = 1'b0;
          core_rst_d = 1'b0;
          done_d     = 1'b1;
        end else go_err = 1'b1;
      end
`endif
      default: ;
    endcase

    if (img_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_d    = ST_CHECK;
      rx_ready_d = 1'b1;
`else
      state_d    = ST_RUN;
      rx_ready_d = 1'b0;
      core_rst_d = 1'b0;
      done_d     = 1'b1;
`endif
    end
    if (go_err) begin
      state_d    = ST_ERR;
      rx_ready_d = 1'b0;
      error_d    = 1'b1;
      core_rst_d = 1'b1;
    end

    if (start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR)) begin
      state_d    = ST_LEN_LO;
      rx_ready_d = 1'b1;
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      wl_d       = '0;
      pk_clear   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wl_q       <= '0;
      len_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
      wl_q       <= wl_d;
      len_q      <= len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level image model predicts writes and final status.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int INST_W = DEF_INST_W;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int MAXW   = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            core_rst, done, error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

  imem_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W), .BYTES_PER_WORD(DEF_BYTES_PER_WORD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus.slave),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[$];
  int          mode  = 0;
  bit          phase = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every write must match the oldest predicted write
  always @(negedge clk) begin
    if (rst && bus.imem_we) begin
      check("rdy_in_write", 64'(bus.rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got write addr %0h data %0h, expected none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.imem_addr), 64'(mon_e.addr));
        check("wr_data", 64'(bus.imem_wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic check_reset(input string name);
    check(name, {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, error, words_loaded},
          {2'b00, {ADDR_W{1'b0}}, {INST_W{1'b0}}, 3'b100, {(ADDR_W+1){1'b0}}});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    bit gap;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      phase = ~phase;
      gap = (mode == 1) ? phase : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.rx_valid = !gap;
      bus.rx_data  = gap ? 8'($urandom) : b;
      acc = !gap && bus.rx_ready;
      @(posedge clk);
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL byte_timeout: byte %02h not accepted in 100 cycles, expected acceptance", b);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_rdy", 64'(bus.rx_ready), 64'd1);
    check("start_status", 64'({core_rst, done, error, words_loaded}), 64'({3'b100, {(ADDR_W+1){1'b0}}}));
  endtask

  task automatic fill_random(input int n, input int bad);
    logic [31:0] w;
    img.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i == bad) w = w | (32'd1 << (INST_W + $urandom_range(0, 31 - INST_W)));
      else          w = w & ((32'd1 << INST_W) - 1);
      img.push_back(w);
    end
  endtask

  // Model: words are written in order until the first word with bits above INST_W set
  task automatic run_load(input int n, input bit bad_sum);
    bit          err;
    int          wrote = 0;
    int          k;
    logic [7:0]  sum = 8'd0;
    logic [31:0] w;
    err = (n > MAXW);
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        if ((w >> INST_W) != 0) err = 1'b1;
        else begin
          exp_q.push_back('{addr: ADDR_W'(i), data: INST_W'(w)});
          wrote++;
        end
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8]);
          sum = sum + w[8*b +: 8];
        end
        if (err) break;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!err) begin
      send_byte(bad_sum ? (sum ^ 8'h5A) : sum);
      err = bad_sum;
    end
`else
    if (bad_sum) $display("note: checksum disabled, bad_sum ignored (sum %02h)", sum);
`endif
    idle();
    k = 0;
    while (!(done || error) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("load_end", 64'(done | error), 64'd1);
    check("error", 64'(error), 64'(err));
    check("done", 64'(done), 64'(!err));
    check("core_rst", 64'(core_rst), 64'(err));
    check("words_loaded", 64'(words_loaded), 64'(wrote));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, bad;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;

    // single known word
    img.delete(); img.push_back(32'h02345678);
    mode = 0; run_load(1, 1'b0);

    mode = 1; fill_random(3, -1); run_load(3, 1'b0);

    // format error: upper bits set
    img.delete(); img.push_back(32'hFC000000);
    mode = 0; run_load(1, 1'b0);

    fill_random(0, -1); run_load(MAXW + 1, 1'b0);
    run_load(0, 1'b0);

    // async reset in the middle of a 4-word load
    fill_random(4, -1);
    pulse_start();
    send_byte(8'd4); send_byte(8'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: INST_W'(img[i])});
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8]);
    end
    idle();
    repeat (2) @(negedge clk);
    check("mid_pending", 64'(exp_q.size()), 64'd0);
    check("mid_wl", 64'(words_loaded), 64'd2);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); check_reset("mid_reset");
    repeat (2) @(negedge clk);
    check_reset("mid_reset_hold");
    rst = 1'b1;
    fill_random(3, -1); mode = 2; run_load(3, 1'b0);

    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 2);
      n    = $urandom_range(1, 8);
      bad  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      fill_random(n, bad);
      run_load(n, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    mode = 2; fill_random(4, -1); run_load(4, 1'b1);
    fill_random(2, -1); run_load(2, 1'b0);
`endif

    // full address range wraps to words_loaded = 2^ADDR_W
    mode = 0; fill_random(MAXW, -1); run_load(MAXW, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
